instr_decode_reg: RTL and testbench
===================================

Name: instr_decode_reg

Overview:
- Instruction register and opcode decoder for the i281 multicycle CPU. It sits between instruction memory and the control FSM.
- On the FSM's IR-load strobe it latches the 16-bit instruction word. In the same edge it registers the 27-bit decoded word the FSM consumes: 23 one-hot opcode bits plus RX/RY fields.
- It also exports the immediate field, a sticky illegal-instruction flag and a fetched-instruction counter.

Parameters:
- COUNT_WIDTH, 16, width of the fetched-instruction counter (wraps modulo 2^COUNT_WIDTH).
- NOOP_WORD, 27'd1, decoded word driven after reset, flush, or on an illegal instruction (NOOP one-hot, RX=RY=0).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ir_load  in  1  IR write strobe from the control FSM (asserted in the IF state).
- flush  in  1  synchronous clear of the decoded word to NOOP_WORD; IR contents are kept.
- instr_in  in  16  instruction word from instruction memory: [15:12] opcode, [11:10] RX, [9:8] RY, [7:0] immediate/offset.
- opcode_out  out  27  registered decoded word: [22:0] one-hot opcode, [26:25] RX, [24:23] RY.
- imm_out  out  8  registered IR[7:0], raw (no sign extension).
- ir_out  out  16  registered raw IR.
- decoded_valid  out  1  high from the first ir_load after reset/flush until the next reset/flush.
- illegal  out  1  sticky; set by an illegal encoding, cleared only by reset.
- fetch_count  out  COUNT_WIDTH  number of accepted ir_load strobes.

Behaviour:
- Reset (synchronous, highest priority) drives all outputs to these values:
  - ir_out=0, imm_out=0, opcode_out=NOOP_WORD.
  - decoded_valid=0, illegal=0, fetch_count=0.
- Load: when ir_load=1 on an edge, ir_out, imm_out and opcode_out are all updated from instr_in at that edge.
  - The decode is computed combinationally from instr_in and registered; there is no separate IR-to-decode stage.
  - opcode_out is therefore valid in the cycle after the load, which is the FSM's ID state.
- Hold: with ir_load=0 and flush=0, all registers hold their values.
- One-hot opcode mapping (opcode_out bit, from instr_in[15:12] and sub-field):
  - 0000 -> bit0 NOOP.
  - 0001 -> INPUT family, variant selected by [9:8]:
    - 00 -> bit1 INPUTC.
    - 01 -> bit2 INPUTCF.
    - 10 -> bit3 INPUTD.
    - 11 -> bit4 INPUTDF.
  - 0010 -> bit5 MOVE.
  - 0011 -> bit6 LOADI/LOADP.
  - 0100 -> bit7 ADD.
  - 0101 -> bit8 ADDI.
  - 0110 -> bit9 SUB.
  - 0111 -> bit10 SUBI.
  - 1000 -> bit11 LOAD.
  - 1001 -> bit12 LOADF.
  - 1010 -> bit13 STORE.
  - 1011 -> bit14 STOREF.
  - 1100 -> SHIFT family, variant selected by [9:8]:
    - 00 -> bit15 SHIFTL.
    - 01 -> bit16 SHIFTR.
    - 1x -> illegal.
  - 1101 -> bit17 CMP.
  - 1110 -> bit18 JUMP.
  - 1111 -> BRANCH family, condition selected by [11:10]:
    - 00 -> bit19 BRE/BRZ.
    - 01 -> bit20 BRNE/BRNZ.
    - 10 -> bit21 BRG.
    - 11 -> bit22 BRGE.
- Register fields: opcode_out[26:25]=instr_in[11:10] (RX) and opcode_out[24:23]=instr_in[9:8] (RY) for every legal instruction, including NOOP/INPUT/SHIFT/BRANCH where the fields double as sub-opcodes.
- Exactly one bit of opcode_out[22:0] is set at all times; this is an invariant the bench asserts every cycle.
- Illegal encoding loaded:
  - opcode_out=NOOP_WORD and illegal<=1.
  - ir_out/imm_out still capture instr_in.
  - decoded_valid<=1 and fetch_count increments.
- fetch_count: +1 per accepted ir_load; wraps from all-ones to 0 without any flag.
- Flush alone: opcode_out<=NOOP_WORD and decoded_valid<=0; ir_out, imm_out, illegal and fetch_count are unchanged.
- Flush and ir_load in the same cycle: the load wins for ir_out, imm_out, opcode_out and fetch_count. decoded_valid<=1, since the new word is valid.
- Reset and ir_load in the same cycle: reset wins, nothing is latched and the counter is not incremented.
- Reset mid-program: the next ir_load behaves as the first fetch after power-up.

Test Plan:
- Reset with ir_load=1, instr_in=16'h4600 -> next cycle: opcode_out=27'd1, ir_out=0, decoded_valid=0, fetch_count=0.
- ir_load=1, instr_in=16'h4600 (ADD RX=1, RY=2) -> next cycle:
  - opcode_out[22:0]=23'h000080, [26:25]=01, [24:23]=10.
  - imm_out=8'h00, decoded_valid=1, fetch_count=1.
  - Then ir_load=0 for 5 cycles -> all outputs unchanged.
- Sweep all 16 opcodes × all [11:8] values -> the one-hot matches the mapping and exactly one bit is set. 16'hCA00 (SHIFT, [9:8]=10) -> opcode_out=27'd1, illegal=1 and stays 1 through later legal loads.
- Load 16'hF9F0 (BRG RX=10, imm=F0) -> opcode_out[21]=1, imm_out=8'hF0. Same cycle flush+ir_load with 16'hE005 -> JUMP bit18, decoded_valid=1. Flush alone next -> opcode_out=27'd1, decoded_valid=0, ir_out=16'hE005.
- COUNT_WIDTH=4, 17 loads -> fetch_count walks 1..15, then 0, then 1.

Source files
------------

// File: rtl/instr_decode_reg.sv
// i281 instruction register plus one-hot opcode decoder. The decode is taken
// straight from instr_in and registered on the same edge that latches the IR.
module instr_decode_reg #(
    parameter int          COUNT_WIDTH = 16,
    parameter logic [26:0] NOOP_WORD   = 27'd1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ir_load,
    input  logic                   flush,
    input  logic [15:0]            instr_in,
    output logic [26:0]            opcode_out,
    output logic [7:0]             imm_out,
    output logic [15:0]            ir_out,
    output logic                   decoded_valid,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    logic [15:0]            ir_q, ir_d;
    logic [26:0]            op_q, op_d;
    logic                   vld_q, vld_d;
    logic                   ill_q, ill_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [3:0]  opc;
    logic [1:0]  rx, ry;
    logic [22:0] dec_hot;
    logic        dec_legal;

    assign opc = instr_in[15:12];
    assign rx  = instr_in[11:10];
    assign ry  = instr_in[9:8];

    // Families 0001, 1100 and 1111 reuse RY/RX as sub-opcodes.
    always_comb begin
        dec_hot   = '0;
        dec_legal = 1'b1;
        unique case (opc)
            4'h0: dec_hot[0] = 1'b1;
            4'h1: begin
                unique case (ry)
                    2'd0: dec_hot[1] = 1'b1;
                    2'd1: dec_hot[2] = 1'b1;
                    2'd2: dec_hot[3] = 1'b1;
                    default: dec_hot[4] = 1'b1;
                endcase
            end
            4'h2: dec_hot[5]  = 1'b1;
            4'h3: dec_hot[6]  = 1'b1;
            4'h4: dec_hot[7]  = 1'b1;
            4'h5: dec_hot[8]  = 1'b1;
            4'h6: dec_hot[9]  = 1'b1;
            4'h7: dec_hot[10] = 1'b1;
            4'h8: dec_hot[11] = 1'b1;
            4'h9: dec_hot[12] = 1'b1;
            4'hA: dec_hot[13] = 1'b1;
            4'hB: dec_hot[14] = 1'b1;
            4'hC: begin
                unique case (ry)
                    2'd0: dec_hot[15] = 1'b1;
                    2'd1: dec_hot[16] = 1'b1;
                    default: dec_legal = 1'b0;
                endcase
            end
            4'hD: dec_hot[17] = 1'b1;
            4'hE: dec_hot[18] = 1'b1;
            default: begin
                unique case (rx)
                    2'd0: dec_hot[19] = 1'b1;
                    2'd1: dec_hot[20] = 1'b1;
                    2'd2: dec_hot[21] = 1'b1;
                    default: dec_hot[22] = 1'b1;
                endcase
            end
        endcase
    end

    // A load overrides a simultaneous flush: the new word is valid.
    always_comb begin
        ir_d  = ir_q;
        op_d  = op_q;
        vld_d = vld_q;
        ill_d = ill_q;
        cnt_d = cnt_q;
        if (ir_load) begin
            ir_d  = instr_in;
            op_d  = dec_legal ? {rx, ry, dec_hot} : NOOP_WORD;
            ill_d = ill_q | ~dec_legal;
            vld_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
        end else if (flush) begin
            op_d  = NOOP_WORD;
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q  <= '0;
            op_q  <= NOOP_WORD;
            vld_q <= 1'b0;
            ill_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ir_q  <= ir_d;
            op_q  <= op_d;
            vld_q <= vld_d;
            ill_q <= ill_d;
            cnt_q <= cnt_d;
        end
    end

    assign ir_out        = ir_q;
    assign imm_out       = ir_q[7:0];
    assign opcode_out    = op_q;
    assign decoded_valid = vld_q;
    assign illegal       = ill_q;
    assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_instr_decode_reg.sv
// Randomized and directed bench for instr_decode_reg with a behavioural model
// of the architectural state, compared on every falling edge.
module tb_instr_decode_reg;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset, ir_load, flush;
    logic [15:0]   instr_in;
    logic [26:0]   opcode_out;
    logic [7:0]    imm_out;
    logic [15:0]   ir_out;
    logic          decoded_valid, illegal;
    logic [CW-1:0] fetch_count;

    instr_decode_reg #(.COUNT_WIDTH(CW), .NOOP_WORD(27'd1)) dut (
        .clock(clock), .reset(reset), .ir_load(ir_load), .flush(flush),
        .instr_in(instr_in), .opcode_out(opcode_out), .imm_out(imm_out),
        .ir_out(ir_out), .decoded_valid(decoded_valid), .illegal(illegal),
        .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model state
    logic [15:0] m_ir  = '0;
    logic [26:0] m_op  = 27'd1;
    bit          m_dv  = 0;
    bit          m_ill = 0;
    int          m_fc  = 0;

    // One-hot position straight from the opcode table; -1 marks illegal.
    function automatic int hot_pos(input logic [15:0] w);
        int op, rx, ry;
        op = int'(w[15:12]); rx = int'(w[11:10]); ry = int'(w[9:8]);
        if (op == 0)  return 0;
        if (op == 1)  return 1 + ry;
        if (op <= 11) return op + 3;
        if (op == 12) return (ry < 2) ? 15 + ry : -1;
        if (op == 13) return 17;
        if (op == 14) return 18;
        return 19 + rx;
    endfunction

    function automatic logic [26:0] exp_word(input logic [15:0] w);
        int p;
        logic [22:0] h;
        p = hot_pos(w);
        if (p < 0) return 27'd1;
        h = '0;
        h[p] = 1'b1;
        return {w[11:10], w[9:8], h};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clock) if (chk_en) begin
        chk("opcode_out", 32'(opcode_out), 32'(m_op));
        chk("ir_out", 32'(ir_out), 32'(m_ir));
        chk("imm_out", 32'(imm_out), 32'(m_ir[7:0]));
        chk("decoded_valid", 32'(decoded_valid), 32'(m_dv));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("fetch_count", 32'(fetch_count), 32'(m_fc % (1 << CW)));
        chk("onehot", $countones(opcode_out[22:0]), 1);
    end

    // Drive one cycle, advance the model at the edge, then settle for literal checks.
    task automatic cyc(input bit r, input bit ld, input bit fl, input logic [15:0] w);
        @(negedge clock);
        #1;
        reset = r; ir_load = ld; flush = fl; instr_in = w;
        @(posedge clock);
        if (r) begin
            m_ir = '0; m_op = 27'd1; m_dv = 0; m_ill = 0; m_fc = 0;
        end else if (ld) begin
            m_ir = w;
            m_op = exp_word(w);
            if (hot_pos(w) < 0) m_ill = 1;
            m_dv = 1;
            m_fc = m_fc + 1;
        end else if (fl) begin
            m_op = 27'd1;
            m_dv = 0;
        end
        #1;
    endtask

    initial begin
        reset = 1; ir_load = 1; flush = 0; instr_in = 16'h4600;
        cyc(1, 1, 0, 16'h4600);
        cyc(1, 1, 0, 16'h4600);
        chk_en = 1;
        chk("rst_op", 32'(opcode_out), 32'd1);
        chk("rst_ir", 32'(ir_out), 32'd0);
        chk("rst_dv", 32'(decoded_valid), 32'd0);
        chk("rst_fc", 32'(fetch_count), 32'd0);

        cyc(0, 1, 0, 16'h4600);
        chk("add_op", 32'(opcode_out), 32'h300_0080);
        chk("add_imm", 32'(imm_out), 32'h00);
        chk("add_dv", 32'(decoded_valid), 32'd1);
        chk("add_fc", 32'(fetch_count), 32'd1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'(($urandom)));
        chk("hold_ir", 32'(ir_out), 32'h4600);
        chk("hold_op", 32'(opcode_out), 32'h300_0080);

        cyc(1, 0, 0, 16'h0);
        cyc(0, 1, 0, 16'hCA00);
        chk("shift_ill_op", 32'(opcode_out), 32'd1);
        chk("shift_ill_flag", 32'(illegal), 32'd1);
        chk("shift_ill_dv", 32'(decoded_valid), 32'd1);
        cyc(0, 1, 0, 16'hC100);
        chk("shiftr_op", 32'(opcode_out), 32'h080_0000 | 32'h1_0000);
        chk("ill_sticky", 32'(illegal), 32'd1);

        for (int i = 0; i < 256; i++) cyc(0, 1, 0, {8'(i), 8'(($urandom))});

        cyc(0, 1, 0, 16'hF9F0);
        chk("brg_bit", 32'(opcode_out[21]), 32'd1);
        chk("brg_imm", 32'(imm_out), 32'hF0);
        cyc(0, 1, 1, 16'hE005);
        chk("jump_bit", 32'(opcode_out[18]), 32'd1);
        chk("jump_dv", 32'(decoded_valid), 32'd1);
        cyc(0, 0, 1, 16'h1234);
        chk("flush_op", 32'(opcode_out), 32'd1);
        chk("flush_dv", 32'(decoded_valid), 32'd0);
        chk("flush_ir", 32'(ir_out), 32'hE005);

        cyc(1, 1, 0, 16'h2000);
        for (int k = 1; k <= 17; k++) begin
            cyc(0, 1, 0, 16'(($urandom)));
            chk("wrap_fc", 32'(fetch_count), 32'(k % 16));
        end

        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 20), 16'(($urandom)));

        @(negedge clock);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
